merge_ctrl_2: RTL

Controller that sequences a two-way merge of sorted 2-tuple runs held in two upstream FIFOs into one downstream FIFO. Each cycle it compares the head keys of the two input FIFOs, pops the smaller, and pushes it downstream, subject to the empty and full flags. It forms the control half of one merge-tree node; the FIFOs themselves stay separate instances.

---
 rtl/merge_pkg.sv | 26 ++
 rtl/run_counter.sv | 40 ++++
 rtl/merge_ctrl_2.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/merge_pkg.sv
// Shared definitions for the merge-tree node controller: state encoding,
// default widths and the key-extraction helper.
package merge_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int KEY_WIDTH_DEF  = 32;
    localparam int LEN_WIDTH_DEF  = 16;

    // Items are zero-extended to this width before key extraction so one
    // helper serves every DATA_WIDTH/KEY_WIDTH combination up to 256 bits.
    localparam int ITEM_MAX_W = 256;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MERGE   = 3'd1;
    localparam logic [2:0] ST_DRAIN_A = 3'd2;
    localparam logic [2:0] ST_DRAIN_B = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    function automatic logic [ITEM_MAX_W-1:0] key_field(
        input logic [ITEM_MAX_W-1:0] item,
        input int unsigned           key_lsb
    );
        return item >> key_lsb;
    endfunction

endpackage

// File: rtl/run_counter.sv
// Per-input run counter: counts items popped from one FIFO for the current
// run and flags when the run is (or is about to be) exhausted.
module run_counter #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_inc,
    input  logic [LEN_WIDTH-1:0] i_limit,
    output logic                 o_exhausted,
    output logic                 o_last
);

    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [LEN_WIDTH:0]   count_next_ext;

    assign o_exhausted    = (count_q == i_limit);
    assign count_next_ext = {1'b0, count_q} + (LEN_WIDTH+1)'(1);
    // The item being popped now is the final one of the run.
    assign o_last         = (count_next_ext == {1'b0, i_limit});

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_inc && !o_exhausted) begin
            count_d = count_q + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/merge_ctrl_2.sv
// Two-way merge controller for one merge-tree node: pops the smaller head of
// two show-ahead FIFOs and pushes it downstream, one item per cycle.
module merge_ctrl_2
    import merge_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int KEY_WIDTH  = KEY_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_run_len,
    input  logic [DATA_WIDTH-1:0] i_a_item,
    input  logic                  i_a_empty,
    output logic                  o_a_read,
    input  logic [DATA_WIDTH-1:0] i_b_item,
    input  logic                  i_b_empty,
    output logic                  o_b_read,
    output logic [DATA_WIDTH-1:0] o_item,
    output logic                  o_write,
    input  logic                  i_out_full,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_WIDTH:0]    o_count
);

    localparam int unsigned KEY_LSB = DATA_WIDTH - KEY_WIDTH;

    logic [2:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] run_len_q, run_len_d;
    logic [LEN_WIDTH:0]   count_q, count_d;
    logic [KEY_WIDTH-1:0] key_a, key_b;
    logic                 a_read, b_read, clear;
    logic                 a_exh, a_last, b_exh, b_last;

    assign key_a = KEY_WIDTH'(key_field(ITEM_MAX_W'(i_a_item), KEY_LSB));
    assign key_b = KEY_WIDTH'(key_field(ITEM_MAX_W'(i_b_item), KEY_LSB));

    run_counter #(.LEN_WIDTH(LEN_WIDTH)) u_cnt_a (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (clear),
        .i_inc       (a_read),
        .i_limit     (run_len_q),
        .o_exhausted (a_exh),
        .o_last      (a_last)
    );

    run_counter #(.LEN_WIDTH(LEN_WIDTH)) u_cnt_b (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (clear),
        .i_inc       (b_read),
        .i_limit     (run_len_q),
        .o_exhausted (b_exh),
        .o_last      (b_last)
    );

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        clear     = 1'b0;
        a_read    = 1'b0;
        b_read    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    run_len_d = i_run_len;
                    clear     = 1'b1;
                    state_d   = (i_run_len == '0) ? ST_DONE : ST_MERGE;
                end
            end
            ST_MERGE: begin
                // Ties go to A so equal keys keep their A-before-B order.
                if (!i_out_full && !i_a_empty && !i_b_empty) begin
                    if (key_a <= key_b) begin
                        a_read = 1'b1;
                        if (a_last) state_d = ST_DRAIN_B;
                    end else begin
                        b_read = 1'b1;
                        if (b_last) state_d = ST_DRAIN_A;
                    end
                end
            end
            ST_DRAIN_A: begin
                if (a_exh) begin
                    state_d = ST_DONE;
                end else if (!i_out_full && !i_a_empty) begin
                    a_read = 1'b1;
                    if (a_last) state_d = ST_DONE;
                end
            end
            ST_DRAIN_B: begin
                if (b_exh) begin
                    state_d = ST_DONE;
                end else if (!i_out_full && !i_b_empty) begin
                    b_read = 1'b1;
                    if (b_last) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A reset cycle must not move data even though state is still live.
        if (i_rst) begin
            a_read = 1'b0;
            b_read = 1'b0;
            clear  = 1'b0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (a_read || b_read) begin
            count_d = count_q + (LEN_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        run_len_q <= run_len_d;
    end

    assign o_a_read = a_read;
    assign o_b_read = b_read;
    assign o_write  = a_read | b_read;
    assign o_item   = a_read ? i_a_item : (b_read ? i_b_item : '0);
    assign o_busy   = (state_q != ST_IDLE);
    assign o_done   = (state_q == ST_DONE) && !i_rst;
    assign o_count  = count_q;

endmodule
